// File: rtl/first_nios2_system_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the M stage: quotient and remainder 34 cycles after start.
// Optional macro DIV_SIGNED_EN enables two's-complement division; otherwise all operations are unsigned.
module first_nios2_system_cpu_div_cell #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M_div_start,
   input  logic              M_div_signed,
   input  logic [DATA_W-1:0] M_div_src1,
   input  logic [DATA_W-1:0] M_div_src2,
   output logic              M_div_busy,
   output logic              M_div_done,
   output logic [DATA_W-1:0] M_div_cell_quotient,
   output logic [DATA_W-1:0] M_div_cell_remainder
);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend, shifted out as quotient bits shift in
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] remo_q, remo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [DATA_W:0]   rem_ext;
   logic [DATA_W+1:0] diff;
   logic [DATA_W-1:0] quot_mag;
   logic [DATA_W-1:0] quot_fix;
   logic [DATA_W-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
   logic sgn_q, sgn_d;
   logic negq_q, negq_d;
   logic negr_q, negr_d;
`else
   logic unused_signed;
   assign unused_signed = M_div_signed;
`endif

   assign rem_ext  = {rem_q, dvd_q[DATA_W-1]};
   assign diff     = {1'b0, rem_ext} - {2'b00, dvs_q};
   assign quot_mag = dvd_q;

`ifdef DIV_SIGNED_EN
   assign quot_fix = negq_q ? -quot_mag : quot_mag;
   assign rem_fix  = negr_q ? -rem_q : rem_q;
`else
   assign quot_fix = quot_mag;
   assign rem_fix  = rem_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_d   = sgn_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
`endif
      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse belongs to the finishing op's FIX slot.
            if (M_div_start && !done_q) begin
               dvd_d   = M_div_src1;
               dvs_d   = M_div_src2;
               busy_d  = 1'b1;
               state_d = S_PREP;
`ifdef DIV_SIGNED_EN
               sgn_d   = M_div_signed;
`endif
            end
         end
         S_PREP: begin
`ifdef DIV_SIGNED_EN
            if (sgn_q) begin
               negq_d = dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1];
               negr_d = dvd_q[DATA_W-1];
               dvd_d  = dvd_q[DATA_W-1] ? -dvd_q : dvd_q;
               dvs_d  = dvs_q[DATA_W-1] ? -dvs_q : dvs_q;
            end else begin
               negq_d = 1'b0;
               negr_d = 1'b0;
            end
`endif
            cnt_d   = CNT_W'(DATA_W);
            rem_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (!diff[DATA_W+1]) begin
               rem_d = diff[DATA_W-1:0];
               dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
            end else begin
               rem_d = rem_ext[DATA_W-1:0];
               dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = S_FIX;
         end
         S_FIX: begin
            // Zero divisor always reports all ones, regardless of the dividend's sign.
            quot_d  = (dvs_q == '0) ? '1 : quot_fix;
            remo_d  = rem_fix;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef DIV_SIGNED_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sgn_q  <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         sgn_q  <= sgn_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end
`endif

   assign M_div_busy           = busy_q;
   assign M_div_done           = done_q;
   assign M_div_cell_quotient  = quot_q;
   assign M_div_cell_remainder = remo_q;

endmodule

// File: tb/tb_first_nios2_system_cpu_div_cell.sv
// Scoreboard bench for the M-stage divider: driver pushes expected results, monitor checks each done pulse.
module tb_first_nios2_system_cpu_div_cell;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        busy, done;
   logic [31:0] quot, rem;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   first_nios2_system_cpu_div_cell #(.DATA_W(32), .CNT_W(6)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .M_div_start         (start),
      .M_div_signed        (sgn),
      .M_div_src1          (src1),
      .M_div_src2          (src2),
      .M_div_busy          (busy),
      .M_div_done          (done),
      .M_div_cell_quotient (quot),
      .M_div_cell_remainder(rem)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Reference: truncating division, remainder follows the dividend; zero divisor -> all ones / src1.
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
`ifndef DIV_SIGNED_EN
      s = 1'b0;
`endif
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      @(negedge clk);
      start = 1'b1; sgn = s; src1 = a; src2 = b;
      @(posedge clk);
      #1;
      if (push) begin
         model(s, a, b, e.q, e.r);
         e.due = cyc + 34;
         exp_q.push_back(e);
      end
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy || done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: timed out with %0d results outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("quotient", quot, e.q);
            chk("remainder", rem, e.r);
            chk("done_cycle", 32'(cyc), 32'(e.due));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         5: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_quot", quot, 32'd0);
      chk("reset_rem", rem, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Latency and handshake on a simple unsigned divide.
      do_op(1'b0, 32'd100, 32'd7, 1'b1);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
      wait_idle();
      @(negedge clk);

      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_idle(); @(negedge clk);
      do_op(1'b0, 32'h1234_5678, 32'd0, 1'b1);           wait_idle(); @(negedge clk);
      do_op(1'b1, 32'h1234_5678, 32'd0, 1'b1);           wait_idle(); @(negedge clk);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_idle(); @(negedge clk);
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);           wait_idle(); @(negedge clk);

      // A start while busy must not disturb the in-flight op or produce a second done.
      do_op(1'b0, 32'd50, 32'd5, 1'b1);
      repeat (8) @(posedge clk);
      do_op(1'b0, 32'd9, 32'd3, 1'b0);
      wait_idle();
      repeat (40) @(negedge clk);

      // Reset mid-operation aborts with no done pulse.
      do_op(1'b0, 32'd1000, 32'd3, 1'b1);
      repeat (14) @(posedge clk);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quot", quot, 32'd0);
      chk("abort_rem", rem, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      do_op(1'b0, 32'd9, 32'd2, 1'b1);
      wait_idle();
      @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         do_op(1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
         wait_idle();
         @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete, outstanding %0d", exp_q.size());
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
